mdu_sequencer: RTL and testbench
================================

# mdu_sequencer

Multi-cycle multiply/divide sequencer owning the HI/LO registers for the pipelined MIPS core. It sits in stage E beside the ALU and accepts one MDU instruction per start. It holds `Busy` for a fixed latency per operation class and commits results to HI/LO at the end of that latency. Its `Busy` output is the `MDUBusyE` term that the hazard unit uses to stall mfhi/mflo and new MDU instructions in stage D.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: Busy cycles for mult/multu, legal range 1..15.
- `DIV_CYCLES`, default 10: Busy cycles for div/divu, legal range 1..15.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `Start`  in  1: the stage-E instruction is an MDU op (mult/multu/div/divu/mthi/mtlo); qualifies `MDUOp`.
- `MDUOp`  in  3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are reserved and have no effect.
- `A`  in  32: forwarded rs value.
- `B`  in  32: forwarded rt value.
- `Req`  in  1: exception/interrupt flush of the stage-E instruction; suppresses a same-cycle `Start`.
- `Busy`  out  1: multi-cycle operation in flight.
- `Done`  out  1: one-cycle pulse in the cycle HI/LO first show a committed mult/div result.
- `HI`  out  32: architectural HI register.
- `LO`  out  32: architectural LO register.

## Operation
- FSM states: IDLE, MULT, DIV. A 4-bit down-counter `cnt` runs in the MULT and DIV states.
- Accept condition: `go = Start & ~Req & ~Busy`.
- IDLE with `go` and op MULT/MULTU:
  - Latch the 64-bit product of `A`×`B` (signed or unsigned) into pending registers.
  - Load `cnt = MULT_CYCLES-1`; next state MULT.
- IDLE with `go` and op DIV/DIVU:
  - Latch quotient into pending LO and remainder into pending HI.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Load `cnt = DIV_CYCLES-1`; next state DIV.
- Divide by zero (B == 0): pending LO = 32'hFFFF_FFFF and pending HI = A, for both DIV and DIVU.
- Signed overflow (A = 32'h8000_0000, B = 32'hFFFF_FFFF, DIV): pending LO = 32'h8000_0000, pending HI = 0.
- MTHI/MTLO with `Start & ~Req`:
  - HI (or LO) ← A at the next edge; the other register is unchanged.
  - No Busy, no Done, state unchanged.
  - Accepted even while Busy. The in-flight op still commits later and overwrites both HI and LO.
- MULT/DIV state: decrement `cnt` each cycle. On the edge where `cnt == 0`, commit pending→HI/LO, return to IDLE, and set `Done` for the next cycle.
- `Start` with a mult/div op while `Busy` is a protocol violation (the hazard unit prevents it). It is defined as ignored: no state change.
- `Req` while Busy does not cancel the in-flight op; that op belongs to an already-committed instruction.
- Reserved `MDUOp` values: no effect under any condition.

## Timing
- Reset values: state IDLE, `cnt` = 0, `Busy` = 0, `Done` = 0, `HI` = 0, `LO` = 0, pending registers = 0.
- `reset` takes priority over all inputs and aborts any in-flight op without committing it.
- `Busy` is registered: state != IDLE.
- If `go` is sampled at edge t:
  - `Busy` = 1 for cycles t+1 .. t+N, where N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO take the new values and `Busy` = 0 in cycle t+N+1.
  - `Done` = 1 in cycle t+N+1 only.
- A new `go` is accepted in cycle t+N+1, giving back-to-back throughput of one op per N+1 cycles.
- MTHI/MTLO sampled at edge t: the new value is visible in cycle t+1.
- Same edge as a commit: an MTHI/MTLO write loses to the commit (commit has priority).
- HI/LO outputs hold their old values throughout Busy; there are no intermediate values.

## Test plan
- Reset, then MULT with A = 32'hFFFF_FFFF, B = 2:
  - Busy high for exactly 5 cycles.
  - Then HI = 32'hFFFF_FFFF, LO = 32'hFFFF_FFFE, with a 1-cycle Done.
  - Repeat as MULTU: HI = 1, LO = 32'hFFFF_FFFE.
- DIV with A = 32'hFFFF_FFF9 (−7), B = 2:
  - After 10 Busy cycles, LO = 32'hFFFF_FFFD and HI = 32'hFFFF_FFFF.
  - DIVU 100/7 gives LO = 14, HI = 2.
- Divide-by-zero and overflow:
  - DIVU with A = 5, B = 0 gives LO = 32'hFFFF_FFFF, HI = 5.
  - DIV with A = 32'h8000_0000, B = 32'hFFFF_FFFF gives LO = 32'h8000_0000, HI = 0.
- Start with Req = 1 (MULT 3×4): Busy never rises, HI/LO unchanged, no Done. The next cycle, Start without Req runs normally: LO = 12.
- MTLO A = 32'h1234 during cycle 2 of a MULT 3×4 busy window:
  - LO = 32'h1234 on the next cycle.
  - At commit, LO = 12 and HI = 0.
  - A second MULT issued while Busy is ignored.
- Reset asserted in cycle 3 of a DIV:
  - Next cycle shows Busy = 0, HI = LO = 0, and no Done pulse afterwards.
  - A fresh MULT after reset completes in 5 cycles.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer owning HI/LO. Results are computed at
// accept time, held in pending registers, and committed after a fixed latency.
module mdu_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] phi_q, phi_d, plo_q, plo_d;
  logic        done_q, done_d;

  logic        busy, go, dz, ovf;
  logic [63:0] prod_s, prod_u;
  logic [31:0] q_s, r_s, q_u, r_u;

  assign busy = (state_q != S_IDLE);
  assign go   = Start & ~Req & ~busy;

  assign prod_u = {32'b0, A} * {32'b0, B};
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});

  // Native signed divide truncates toward zero with dividend-signed remainder;
  // the zero-divisor and overflow cases are overridden below.
  assign q_u = A / B;
  assign r_u = A % B;
  assign q_s = $unsigned($signed(A) / $signed(B));
  assign r_s = $unsigned($signed(A) % $signed(B));
  assign dz  = (B == 32'd0);
  assign ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    done_d  = 1'b0;

    // Moves to HI/LO bypass the busy interlock; a same-edge commit wins below.
    if (Start && !Req && MDUOp == OP_MTHI) hi_d = A;
    if (Start && !Req && MDUOp == OP_MTLO) lo_d = A;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          case (MDUOp)
            OP_MULT, OP_MULTU: begin
              {phi_d, plo_d} = (MDUOp == OP_MULT) ? prod_s : prod_u;
              cnt_d   = 4'(MULT_CYCLES - 1);
              state_d = S_MULT;
            end
            OP_DIV, OP_DIVU: begin
              if (dz) begin
                plo_d = 32'hFFFF_FFFF;
                phi_d = A;
              end else if (MDUOp == OP_DIV && ovf) begin
                plo_d = 32'h8000_0000;
                phi_d = 32'd0;
              end else if (MDUOp == OP_DIV) begin
                plo_d = q_s;
                phi_d = r_s;
              end else begin
                plo_d = q_u;
                phi_d = r_u;
              end
              cnt_d   = 4'(DIV_CYCLES - 1);
              state_d = S_DIV;
            end
            default: ;
          endcase
        end
      end
      S_MULT, S_DIV: begin
        if (cnt_q == 4'd0) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Busy = busy;
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: latency, results, move ops, flush and reset.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDUOp;
  logic [31:0] A, B;
  logic        Req;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int n_tests = 0;
  int n_fail  = 0;

  mdu_sequencer dut (
    .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp), .A(A), .B(B),
    .Req(Req), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, count Busy cycles, verify HI/LO hold and Done stays low
  // while busy, then check the commit cycle. Returns in the commit cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] hi0, lo0;
    int cyc;
    int bad;
    hi0 = HI; lo0 = LO;
    Start = 1'b1; MDUOp = op; A = a; B = b;
    step();
    Start = 1'b0; A = 32'd0; B = 32'd0;
    cyc = 0; bad = 0;
    while (Busy && cyc < 40) begin
      if (HI !== hi0 || LO !== lo0 || Done !== 1'b0) bad++;
      cyc++;
      step();
    end
    chk({tag, "_busy_cycles"}, cyc, n);
    chk({tag, "_hold"}, bad, 0);
    chk({tag, "_done"}, {31'b0, Done}, 32'd1);
    chk({tag, "_hi"}, HI, ehi);
    chk({tag, "_lo"}, LO, elo);
  endtask

  initial begin
    int dcnt;
    reset = 1'b1; Start = 1'b0; MDUOp = 3'd0; A = 32'd0; B = 32'd0; Req = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_done", {31'b0, Done}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);

    run_op("mult",  3'd0, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'd1, 32'hFFFF_FFFE);
    run_op("div",   3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",  3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    run_op("divu0", 3'd3, 32'd5, 32'd0, 10, 32'd5, 32'hFFFF_FFFF);
    run_op("div0",  3'd2, 32'hFFFF_FFF9, 32'd0, 10, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    step();
    chk("done_one_cycle", {31'b0, Done}, 32'd0);

    // Flushed start: nothing happens
    Start = 1'b1; Req = 1'b1; MDUOp = 3'd0; A = 32'd3; B = 32'd4;
    step();
    Start = 1'b0; Req = 1'b0;
    chk("req_busy", {31'b0, Busy}, 32'd0);
    chk("req_done", {31'b0, Done}, 32'd0);
    chk("req_hi", HI, 32'd0);
    chk("req_lo", LO, 32'h8000_0000);
    run_op("mult_after_req", 3'd0, 32'd3, 32'd4, 5, 32'd0, 32'd12);

    // Idle MTHI and reserved op
    Start = 1'b1; MDUOp = 3'd4; A = 32'hABCD;
    step();
    Start = 1'b0;
    chk("mthi_hi", HI, 32'hABCD);
    chk("mthi_lo", LO, 32'd12);
    chk("mthi_busy", {31'b0, Busy}, 32'd0);
    Start = 1'b1; MDUOp = 3'd6; A = 32'hDEAD; B = 32'd1;
    step();
    Start = 1'b0;
    chk("rsv_hi", HI, 32'hABCD);
    chk("rsv_lo", LO, 32'd12);
    chk("rsv_busy", {31'b0, Busy}, 32'd0);

    // MTLO in busy cycle 2 of a MULT, then an ignored MULT while busy
    Start = 1'b1; MDUOp = 3'd0; A = 32'd3; B = 32'd4;
    step();
    Start = 1'b0;
    step();
    Start = 1'b1; MDUOp = 3'd5; A = 32'h1234;
    step();
    chk("mtlo_lo", LO, 32'h1234);
    chk("mtlo_hi", HI, 32'hABCD);
    chk("mtlo_busy", {31'b0, Busy}, 32'd1);
    MDUOp = 3'd0; A = 32'd5; B = 32'd5;
    step();
    Start = 1'b0;
    dcnt = 0;
    while (Busy && dcnt < 20) begin dcnt++; step(); end
    chk("mtlo_wait", dcnt, 2);
    chk("mtlo_commit_done", {31'b0, Done}, 32'd1);
    chk("mtlo_commit_lo", LO, 32'd12);
    chk("mtlo_commit_hi", HI, 32'd0);
    step();
    chk("ignored_busy", {31'b0, Busy}, 32'd0);
    chk("ignored_lo", LO, 32'd12);

    // Reset in cycle 3 of a DIV
    run_op("mult_pre_rst", 3'd0, 32'd7, 32'd9, 5, 32'd0, 32'd63);
    Start = 1'b1; MDUOp = 3'd3; A = 32'd100; B = 32'd7;
    step();
    Start = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("div_rst_busy", {31'b0, Busy}, 32'd0);
    chk("div_rst_hi", HI, 32'd0);
    chk("div_rst_lo", LO, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (Done || Busy) dcnt++;
      step();
    end
    chk("div_rst_no_done", dcnt, 0);
    run_op("mult_post_rst", 3'd0, 32'd3, 32'd4, 5, 32'd0, 32'd12);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
